uart_rx_parity: RTL
===================

# uart_rx_parity

Serial receive end of the parity-checked UART link. Samples the asynchronous `rx` line with 16x oversampling from an internal baud-tick divider and deserialises one frame: start bit, DBIT data bits LSB first, one parity bit, stop. It delivers each word with a one-cycle done strobe and registered parity and framing error flags. It sits between the pad and the receive FIFO; `rx_done_tick` is the FIFO write strobe.

## Interface
- DBIT, 8: data bits per frame.
- SB_TICK, 16: oversample ticks for the stop bit (16/24/32 = 1/1.5/2 stop bits).
- DVSR, 163: clocks per oversample tick (50 MHz / (16 × 19200)).
- DVSR_BIT, 8: width of the divider counter.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.

- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-low reset (reset==0 resets on the next clk edge).
- rx, input, 1: serial line, asynchronous, idles high.
- dout, output, DBIT: last received word; held until the next frame completes.
- rx_done_tick, output, 1: one-cycle pulse when a frame completes, errored frames included.
- parity_err, output, 1: parity result of the last frame; valid with and held after rx_done_tick.
- frame_err, output, 1: stop bit sampled low on the last frame; held like parity_err.
- busy, output, 1: high in any state other than IDLE.

## Operation
- Synchroniser:
  - `rx` passes through 2 flops giving `rx_s`.
  - All logic uses `rx_s` and a registered copy `rx_d` for edge detection.
- Tick generator:
  - Free-running counter 0..DVSR-1.
  - `tick` is high for one clk when the counter equals DVSR-1, then it wraps to 0.
  - Runs in all states.
- Counters:
  - `s` (4 bits) counts oversample ticks.
  - `n` counts bits, width clog2(DBIT).
  - `b` is a DBIT-wide shift register.
- IDLE:
  - Waits for a falling edge (`rx_d`=1, `rx_s`=0).
  - On the edge: s←0, go to START.
  - A line that is already low does not start a frame; a high must be seen first.
- START, on each tick:
  - If s==7 and `rx_s`==0: s←0, n←0, go to DATA.
  - If s==7 and `rx_s`==1: false start, return to IDLE with no strobe.
  - Otherwise s←s+1.
- DATA, on each tick:
  - At s==15: s←0, b←{rx_s, b[DBIT-1:1]} (LSB first).
  - If n==DBIT-1 go to PARITY, else n←n+1.
- PARITY, on tick at s==15:
  - s←0.
  - Latch perr = (^b) ^ rx_s ^ PARITY_ODD.
  - Go to STOP.
- STOP, on tick at s==SB_TICK-1:
  - dout←b, parity_err←perr, frame_err←~rx_s.
  - rx_done_tick←1 for exactly one clk.
  - Go to IDLE.
- Outputs are registered; dout and the flags change only on the done cycle.
- Break condition (line held low):
  - Completes with frame_err=1 and dout=0.
  - IDLE then waits for `rx` to return high before accepting the next falling edge.
- Back-to-back frames: a start edge arriving right after the stop sample is accepted, because IDLE is entered on the same cycle as rx_done_tick.
- Reset mid-frame:
  - Aborts immediately to IDLE with no strobe.
  - All outputs return to reset values.
  - The tick counter clears.

## Timing
- Reset values:
  - dout=0, rx_done_tick=0, parity_err=0, frame_err=0, busy=0.
  - State IDLE; s, n, b and the tick counter all 0.
  - Both synchroniser flops reset to 1 (idle line).
- Input latency: 2 clk from `rx` to `rx_s`; 1 more clk for edge detection.
- Sample points: data and parity bits are sampled at bit centres, within ±1 tick (16 × DVSR clk per bit).
- Frame latency: from the `rx` falling edge to rx_done_tick is about (8 + 16·(DBIT+1) + SB_TICK) ticks, plus up to DVSR clk of divider phase, plus 3 clk.
- rx_done_tick is never high on two consecutive clk cycles.
- No back-pressure: the downstream FIFO must accept a write on every strobe.

## Test plan
Use DVSR=4 (64 clk per bit), DBIT=8, even parity, clk period 20 ns.
- Send 0xE5 with parity bit 1 and stop bit 1 → exactly one rx_done_tick; dout=0xE5, parity_err=0, frame_err=0.
- Send 0x95 with a wrong parity bit of 1 → dout=0x95, parity_err=1, frame_err=0.
- Send 0xCC with correct parity 0 and the stop bit driven 0 → dout=0xCC, frame_err=1; no second strobe while the line is held low.
- Low glitch of 20 clk on an idle line → no rx_done_tick, busy returns to 0 after the START check.
- Assert reset=0 for 1 clk during bit 3 of a frame, then send a clean 0x3A → all outputs 0 after reset; the 0x3A frame is received with no errors.
- Two frames 0x01 and 0xFF back to back, with the second start bit immediately after the first stop bit → two strobes in order with dout=0x01 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_rx_parity_if.sv
// uart_rx_parity_if: serial receive bundle between the pad-side driver and the
// UART receiver.
//   rx           : serial line (idles high)
//   dout         : last received word
//   rx_done_tick : one-cycle frame-complete strobe (FIFO write)
//   parity_err   : parity result of the last frame
//   frame_err    : stop bit sampled low on the last frame
//   busy         : receiver is not idle
// master = line driver / FIFO side, slave = receiver.
interface uart_rx_parity_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            parity_err;
    logic            frame_err;
    logic            busy;

    modport master (
        output rx,
        input  dout, rx_done_tick, parity_err, frame_err, busy
    );

    modport slave (
        input  rx,
        output dout, rx_done_tick, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 16x-oversampled UART receiver with parity and framing checks.
// Frame: start, DBIT data bits LSB first, one parity bit, stop.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : slave modport of uart_rx_parity_if (rx in; dout, rx_done_tick,
//           parity_err, frame_err, busy out)
// DBIT must be at least 2.
module uart_rx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR       = 163,
    parameter int DVSR_BIT   = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_parity_if.slave   bus
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    // 4 bits covers one stop bit; longer stop periods need a wider counter.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // synchroniser + edge-detect copy, all preset to idle-high
    logic rx_m, rx_s, rx_d;

    logic [DVSR_BIT-1:0] cnt_q;
    logic                tick;

    state_t          state_q, state_n;
    logic [SW-1:0]   s_q, s_n;
    logic [NW-1:0]   n_q, n_n;
    logic [DBIT-1:0] b_q, b_n;
    logic            perr_q, perr_n;
    logic [DBIT-1:0] dout_q, dout_n;
    logic            par_q, par_n;
    logic            ferr_q, ferr_n;
    logic            done_q, done_n;

    assign tick = (cnt_q == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
            cnt_q <= '0;
        end else begin
            rx_m  <= bus.rx;
            rx_s  <= rx_m;
            rx_d  <= rx_s;
            cnt_q <= tick ? '0 : cnt_q + DVSR_BIT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            n_q     <= n_n;
            b_q     <= b_n;
            perr_q  <= perr_n;
            dout_q  <= dout_n;
            par_q   <= par_n;
            ferr_q  <= ferr_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        n_n     = n_q;
        b_n     = b_q;
        perr_n  = perr_q;
        dout_n  = dout_q;
        par_n   = par_q;
        ferr_n  = ferr_q;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // needs a high-to-low transition; a line stuck low never starts
                if (rx_d && !rx_s) begin
                    s_n     = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            s_n     = '0;
                            n_n     = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_n = '0;
                        b_n = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) state_n = PARITY;
                        else                      n_n     = n_q + NW'(1);
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_n     = '0;
                        perr_n  = (^b_q) ^ rx_s ^ ODD;
                        state_n = STOP;
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        dout_n  = b_q;
                        par_n   = perr_q;
                        ferr_n  = ~rx_s;
                        done_n  = 1'b1;
                        // IDLE in the strobe cycle so a back-to-back start is caught
                        state_n = IDLE;
                    end else begin
                        s_n = s_q + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.parity_err   = par_q;
    assign bus.frame_err    = ferr_q;
    assign bus.busy         = (state_q != IDLE);
endmodule
